hilo_muldiv_unit: RTL and testbench

Multi-cycle multiply/divide engine that produces the HI/LO register pair. The datapath issues a mult/div with a start pulse. Results are read back later through a HI/LO read port, the mfhi/mflo path. This replaces the single-cycle A*B product with an iterative radix-2 unit and adds signed/unsigned divide.

---
 rtl/hilo_muldiv_unit.sv | 165 ++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 120 ++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative radix-2 multiply/divide engine that owns the HI/LO pair.
// Multiply is shift-add and divide is restoring. Both take WIDTH CALC cycles, then
// one FIX cycle for the sign correction and the HI/LO write, then one DONE cycle.
// A divide by zero skips CALC entirely.
// Optional feature macro: MULDIV_MTHILO_EN adds an mthi/mtlo write port
// (mtEn/mtSel/mtData) that is honoured only in IDLE.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       MulDivOp,
  input  logic             start,
  input  logic             HiLoSel,
`ifdef MULDIV_MTHILO_EN
  input  logic             mtEn,
  input  logic             mtSel,
  input  logic [WIDTH-1:0] mtData,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HiLoOut,
  output logic             divZero
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hi, lo;

  // Operation context latched at start; data only, so it carries no reset.
  logic             is_div, is_signed, sign_a, sign_b, dz;
  logic [WIDTH-1:0] opnd;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0] upper;  // product upper half or partial remainder
  logic [WIDTH-1:0] lower;  // multiplier / product lower half, or dividend / quotient

  logic             b_zero;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH-1:0] div_trial;
  logic             div_ge;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  // Operand magnitudes, one iteration step and the FIX-cycle sign correction.
  always_comb begin
    b_zero    = (B == '0);
    abs_a     = (!MulDivOp[0] && A[WIDTH-1]) ? -A : A;
    abs_b     = (!MulDivOp[0] && B[WIDTH-1]) ? -B : B;
    // The multiply sum keeps its carry so the right shift loses nothing.
    mul_sum   = lower[0] ? ({1'b0, upper} + {1'b0, opnd}) : {1'b0, upper};
    div_shift = {upper, lower[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
    // When the trial subtraction succeeds, the difference is below the divisor and fits in WIDTH bits.
    div_trial = div_shift[WIDTH-1:0] - opnd;
    prod      = {upper, lower};
    prod_fix  = (is_signed && (sign_a ^ sign_b)) ? -prod : prod;
    quot_fix  = (is_signed && (sign_a ^ sign_b)) ? -lower : lower;
    rem_fix   = (is_signed && sign_a) ? -upper : upper;
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = (MulDivOp[1] && b_zero) ? S_FIX : S_CALC;
      S_CALC: begin
        busy = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) state_nxt = S_FIX;
      end
      S_FIX: begin
        busy      = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, counter, divZero flag and the architectural HI/LO registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      divZero <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt     <= '0;
            divZero <= MulDivOp[1] && b_zero;
          end
`ifdef MULDIV_MTHILO_EN
          else if (mtEn) begin
            if (mtSel) hi <= mtData;
            else       lo <= mtData;
          end
`endif
        end
        S_CALC: cnt <= cnt + CNT_W'(1);
        S_FIX: begin
          if (dz) begin
            hi <= lower;
            lo <= '1;
          end else if (is_div) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

  // Operand capture at start and one shift-add / restoring step per CALC cycle.
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: begin
        if (start) begin
          is_div    <= MulDivOp[1];
          is_signed <= ~MulDivOp[0];
          sign_a    <= A[WIDTH-1];
          sign_b    <= B[WIDTH-1];
          dz        <= MulDivOp[1] && b_zero;
          upper     <= '0;
          if (MulDivOp[1]) begin
            // On a divide by zero, the raw dividend is kept so that it is returned in HI.
            lower <= b_zero ? A : abs_a;
            opnd  <= abs_b;
          end else begin
            lower <= abs_b;
            opnd  <= abs_a;
          end
        end
      end
      S_CALC: begin
        if (is_div) begin
          upper <= div_ge ? div_trial : div_shift[WIDTH-1:0];
          lower <= {lower[WIDTH-2:0], div_ge};
        end else begin
          upper <= mul_sum[WIDTH:1];
          lower <= {mul_sum[0], lower[WIDTH-1:1]};
        end
      end
      default: ;
    endcase
  end

  assign HiLoOut = HiLoSel ? hi : lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed testbench for hilo_muldiv_unit with hand-computed HI/LO results.
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] A, B;
  logic [1:0]  MulDivOp;
  logic        start, HiLoSel;
  logic        busy, done, divZero;
  logic [31:0] HiLoOut;

  int checks = 0;
  int errors = 0;
  logic [31:0] prev_lo = 32'h0;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  hilo_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .MulDivOp(MulDivOp), .start(start),
    .HiLoSel(HiLoSel), .busy(busy), .done(done), .HiLoOut(HiLoOut), .divZero(divZero)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one operation in the cycle after the current one and follows it to done.
  // With poke set, a conflicting start is raised mid-operation and must be ignored.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_dz, input bit poke);
    int n;
    @(posedge clk); #1;
    MulDivOp = op; A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; A = 32'hDEADBEEF; B = 32'h0; MulDivOp = OP_DIVU;
    n = 1;
    while (!done && n < 100) begin
      if (poke && n == 5) begin
        HiLoSel = 1'b0; #1;
        check_val({tag, "_lo_held_busy"}, {32'h0, HiLoOut}, {32'h0, prev_lo});
        check_val({tag, "_busy"}, {63'h0, busy}, 64'h1);
        start = 1'b1; A = 32'h5; B = 32'h5; MulDivOp = OP_MULTU;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check_val({tag, "_latency"}, 64'(n), 64'(exp_lat));
    check_val({tag, "_busy_at_done"}, {63'h0, busy}, 64'h0);
    check_val({tag, "_divzero"}, {63'h0, divZero}, {63'h0, exp_dz});
    HiLoSel = 1'b1; #1;
    check_val({tag, "_hi"}, {32'h0, HiLoOut}, {32'h0, exp_hi});
    HiLoSel = 1'b0; #1;
    check_val({tag, "_lo"}, {32'h0, HiLoOut}, {32'h0, exp_lo});
    prev_lo = exp_lo;
  endtask

  initial begin
    bit seen_done;
    rst = 1'b0; A = 32'h0; B = 32'h0; MulDivOp = OP_MULT; start = 1'b0; HiLoSel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", {63'h0, busy}, 64'h0);
    check_val("rst_done", {63'h0, done}, 64'h0);
    check_val("rst_divzero", {63'h0, divZero}, 64'h0);
    check_val("rst_lo", {32'h0, HiLoOut}, 64'h0);
    HiLoSel = 1'b1; #1;
    check_val("rst_hi", {32'h0, HiLoOut}, 64'h0);
    rst = 1'b1;

    run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_val("done_one_cycle", {63'h0, done}, 64'h0);

    run_op("mult_neg", OP_MULT, 32'hFFFFFFF9, 32'h3, 34, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b1);
    run_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'h2, 34, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
    run_op("div_negb", OP_DIV, 32'h7, 32'hFFFFFFFE, 34, 32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b0);
    run_op("divu", OP_DIVU, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0, 1'b0);
    run_op("divu_zero", OP_DIVU, 32'h12345678, 32'h0, 2, 32'h12345678, 32'hFFFFFFFF, 1'b1, 1'b0);
    run_op("divu_b2b", OP_DIVU, 32'd9, 32'd3, 34, 32'd0, 32'd3, 1'b0, 1'b0);
    run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 34, 32'h0, 32'h80000000, 1'b0, 1'b0);

    // Reset asserted in the middle of a MULT.
    @(posedge clk); #1;
    MulDivOp = OP_MULT; A = 32'h3; B = 32'h5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_val("midrst_busy", {63'h0, busy}, 64'h0);
    HiLoSel = 1'b0; #1;
    check_val("midrst_lo", {32'h0, HiLoOut}, 64'h0);
    HiLoSel = 1'b1; #1;
    check_val("midrst_hi", {32'h0, HiLoOut}, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    check_val("midrst_no_done", {63'h0, seen_done}, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
